// File: rtl/sa_os_stream.sv
// sa_os_stream: output-stationary systolic matrix multiply, OUT = X * W.
// X lanes enter on the left edge, W lanes on the top edge; each PE keeps a
// saturating-on-readout fixed-point accumulator. Results drain one row per
// valid/ready handshake.
//
// Ports:
//   I_CLK, I_SYNC_RST        clock, synchronous active-high reset
//   I_START, I_K_LEN         start pulse (IDLE only), inner dimension K
//   O_BUSY                   state is not IDLE
//   I_IN_VLD, O_IN_RDY       input beat handshake (ready only in LOAD)
//   I_X, I_W                 X column k (SA_R lanes), W row k (SA_C lanes)
//   O_OUT_VLD, I_OUT_RDY     result row handshake
//   O_OUT_ROW, O_ROW_IDX     saturated result row and its index
//   O_DONE                   one-cycle pulse after the last row handshake
module sa_os_stream #(
    parameter int D_W    = 16,
    parameter int FRAC_W = 13,
    parameter int SA_R   = 16,
    parameter int SA_C   = 16,
    parameter int K_MAX  = 64,
    localparam int K_W   = $clog2(K_MAX + 1),
    localparam int RI_W  = $clog2(SA_R)
) (
    input  logic                I_CLK,
    input  logic                I_SYNC_RST,
    input  logic                I_START,
    input  logic [K_W-1:0]      I_K_LEN,
    output logic                O_BUSY,
    input  logic                I_IN_VLD,
    output logic                O_IN_RDY,
    input  logic [SA_R*D_W-1:0] I_X,
    input  logic [SA_C*D_W-1:0] I_W,
    output logic                O_OUT_VLD,
    input  logic                I_OUT_RDY,
    output logic [SA_C*D_W-1:0] O_OUT_ROW,
    output logic [RI_W-1:0]     O_ROW_IDX,
    output logic                O_DONE
);
    localparam int AW  = 2 * D_W + $clog2(K_MAX);
    localparam int F_W = $clog2(SA_R + SA_C);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DRAIN} state_t;

    state_t          r_state;
    logic [K_W-1:0]  r_k;
    logic [K_W-1:0]  r_beat;
    logic [F_W-1:0]  r_flush;
    logic [RI_W-1:0] r_row;
    logic            r_done;

    logic            w_accept;
    logic            w_clr;
    logic [K_W-1:0]  w_k_clamp;

    assign w_accept  = (r_state == S_LOAD) && I_IN_VLD;
    assign w_clr     = (r_state == S_IDLE) && I_START;
    assign w_k_clamp = (I_K_LEN > K_W'(K_MAX)) ? K_W'(K_MAX) : I_K_LEN;

    // Control FSM
    always_ff @(posedge I_CLK) begin
        if (I_SYNC_RST) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_beat  <= '0;
            r_flush <= '0;
            r_row   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (I_START) begin
                        r_k     <= w_k_clamp;
                        r_beat  <= '0;
                        r_flush <= '0;
                        r_state <= (w_k_clamp == '0) ? S_FLUSH : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        if (r_beat == r_k - K_W'(1)) begin
                            r_state <= S_FLUSH;
                            r_flush <= '0;
                        end else begin
                            r_beat <= r_beat + K_W'(1);
                        end
                    end
                end
                S_FLUSH: begin
                    // SA_R+SA_C-1 cycles: the last beat reaches the far corner PE
                    if (r_flush == F_W'(SA_R + SA_C - 2)) begin
                        r_state <= S_DRAIN;
                        r_row   <= '0;
                    end else begin
                        r_flush <= r_flush + F_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (I_OUT_RDY) begin
                        if (r_row == RI_W'(SA_R - 1)) begin
                            r_state <= S_IDLE;
                            r_row   <= '0;
                            r_done  <= 1'b1;
                        end else begin
                            r_row <= r_row + RI_W'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Skewed edge feeds: {valid, data}. Lane n has n+1 stages so beat k
    // accepted at edge t is consumed by PE(i,j) at edge t+i+j+1.
    logic [D_W:0] w_x_edge [SA_R];
    logic [D_W:0] w_w_edge [SA_C];

    for (genvar i = 0; i < SA_R; i++) begin : g_xsk
        logic [D_W:0] r_sk [i+1];
        always_ff @(posedge I_CLK) begin
            if (I_SYNC_RST) begin
                for (int unsigned s = 0; s <= i; s++) r_sk[s] <= '0;
            end else begin
                r_sk[0] <= {w_accept, I_X[i*D_W +: D_W]};
                for (int unsigned s = 1; s <= i; s++) r_sk[s] <= r_sk[s-1];
            end
        end
        assign w_x_edge[i] = r_sk[i];
    end

    for (genvar j = 0; j < SA_C; j++) begin : g_wsk
        logic [D_W:0] r_sk [j+1];
        always_ff @(posedge I_CLK) begin
            if (I_SYNC_RST) begin
                for (int unsigned s = 0; s <= j; s++) r_sk[s] <= '0;
            end else begin
                r_sk[0] <= {w_accept, I_W[j*D_W +: D_W]};
                for (int unsigned s = 1; s <= j; s++) r_sk[s] <= r_sk[s-1];
            end
        end
        assign w_w_edge[j] = r_sk[j];
    end

    // PE grid: forwarded operands only exist where a neighbour consumes them
    logic [D_W:0]          w_xf  [SA_R][SA_C-1];
    logic [D_W:0]          w_wf  [SA_R-1][SA_C];
    logic signed [AW-1:0]  w_acc [SA_R][SA_C];

    for (genvar i = 0; i < SA_R; i++) begin : g_row
        for (genvar j = 0; j < SA_C; j++) begin : g_pe
            logic [D_W:0]             w_xi;
            logic [D_W:0]             w_wi;
            logic signed [2*D_W-1:0]  w_xs;
            logic signed [2*D_W-1:0]  w_ws;
            logic signed [2*D_W-1:0]  w_prod;
            logic signed [AW-1:0]     r_acc;

            if (j == 0) begin : g_xl
                assign w_xi = w_x_edge[i];
            end else begin : g_xm
                assign w_xi = w_xf[i][j-1];
            end
            if (i == 0) begin : g_wt
                assign w_wi = w_w_edge[j];
            end else begin : g_wm
                assign w_wi = w_wf[i-1][j];
            end

            assign w_xs   = {{D_W{w_xi[D_W-1]}}, w_xi[D_W-1:0]};
            assign w_ws   = {{D_W{w_wi[D_W-1]}}, w_wi[D_W-1:0]};
            assign w_prod = w_xs * w_ws;

            always_ff @(posedge I_CLK) begin
                if (I_SYNC_RST || w_clr) begin
                    r_acc <= '0;
                end else if (w_xi[D_W] && w_wi[D_W]) begin
                    r_acc <= r_acc + {{(AW-2*D_W){w_prod[2*D_W-1]}}, w_prod};
                end
            end
            assign w_acc[i][j] = r_acc;

            if (j < SA_C - 1) begin : g_xfw
                logic [D_W:0] r_x;
                always_ff @(posedge I_CLK) begin
                    if (I_SYNC_RST) r_x <= '0;
                    else            r_x <= w_xi;
                end
                assign w_xf[i][j] = r_x;
            end
            if (i < SA_R - 1) begin : g_wfw
                logic [D_W:0] r_w;
                always_ff @(posedge I_CLK) begin
                    if (I_SYNC_RST) r_w <= '0;
                    else            r_w <= w_wi;
                end
                assign w_wf[i][j] = r_w;
            end
        end
    end

    // Floor shift by FRAC_W, then clamp to the signed D_W range
    function automatic logic [D_W-1:0] f_sat(input logic signed [AW-1:0] a);
        logic signed [AW-1:0] s;
        s = a >>> FRAC_W;
        if ((s[AW-1:D_W-1] == '0) || (s[AW-1:D_W-1] == '1)) return s[D_W-1:0];
        return s[AW-1] ? {1'b1, {(D_W-1){1'b0}}} : {1'b0, {(D_W-1){1'b1}}};
    endfunction

    logic [SA_C*D_W-1:0] w_out_row;
    always_comb begin
        w_out_row = '0;
        if (r_state == S_DRAIN) begin
            for (int unsigned j = 0; j < SA_C; j++)
                w_out_row[j*D_W +: D_W] = f_sat(w_acc[r_row][j]);
        end
    end

    assign O_BUSY    = (r_state != S_IDLE);
    assign O_IN_RDY  = (r_state == S_LOAD);
    assign O_OUT_VLD = (r_state == S_DRAIN);
    assign O_OUT_ROW = w_out_row;
    assign O_ROW_IDX = r_row;
    assign O_DONE    = r_done;

endmodule

// File: tb/tb_sa_os_stream.sv
// Bench for sa_os_stream at SA_R=SA_C=4: a table of directed jobs with
// hand-computed result rows, a mid-operation reset sequence, and random
// jobs checked against a plain-arithmetic matrix-multiply model.
module tb_sa_os_stream;
    localparam int D_W = 16, FRAC_W = 13, SA_R = 4, SA_C = 4, K_MAX = 64;

    logic        I_CLK = 1'b0;
    logic        I_SYNC_RST;
    logic        I_START;
    logic [6:0]  I_K_LEN;
    logic        O_BUSY;
    logic        I_IN_VLD;
    logic        O_IN_RDY;
    logic [63:0] I_X;
    logic [63:0] I_W;
    logic        O_OUT_VLD;
    logic        I_OUT_RDY;
    logic [63:0] O_OUT_ROW;
    logic [1:0]  O_ROW_IDX;
    logic        O_DONE;

    sa_os_stream #(.D_W(D_W), .FRAC_W(FRAC_W), .SA_R(SA_R), .SA_C(SA_C), .K_MAX(K_MAX)) dut (
        .I_CLK(I_CLK), .I_SYNC_RST(I_SYNC_RST), .I_START(I_START), .I_K_LEN(I_K_LEN),
        .O_BUSY(O_BUSY), .I_IN_VLD(I_IN_VLD), .O_IN_RDY(O_IN_RDY), .I_X(I_X), .I_W(I_W),
        .O_OUT_VLD(O_OUT_VLD), .I_OUT_RDY(I_OUT_RDY), .O_OUT_ROW(O_OUT_ROW),
        .O_ROW_IDX(O_ROW_IDX), .O_DONE(O_DONE)
    );

    always #5 I_CLK = ~I_CLK;

    int cyc = 0;
    always @(posedge I_CLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] gx [SA_R][K_MAX];   // X[i][k]
    logic [15:0] gw [K_MAX][SA_C];   // W[k][j]
    logic [63:0] exp_rows [SA_R];

    typedef struct {
        logic [6:0]         k;
        int                 pat;     // 0 identity, 1 +max*+max, 2 -min*+max
        int                 bub;     // 0 continuous, 1 alternating (low first)
        int                 st_row;
        int                 st_len;
        bit                 glitch;  // pulse I_START with K=1 during LOAD
        int                 first;   // expected first O_OUT_VLD cycle
        logic [3:0][63:0]   rows;
    } vec_t;

    vec_t tbl [7];

    task automatic step();
        @(posedge I_CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting (cycle %0d)", nm, cyc);
    endtask

    function automatic logic [63:0] rep4(input logic [15:0] v);
        return {4{v}};
    endfunction

    // Reference: exact integer dot product, floor-shift, clamp to int16
    function automatic logic [63:0] model_row(input int r, input int k);
        logic [63:0] row;
        longint acc;
        logic [15:0] v;
        row = '0;
        for (int j = 0; j < SA_C; j++) begin
            acc = 0;
            for (int kk = 0; kk < k; kk++)
                acc += longint'($signed(gx[r][kk])) * longint'($signed(gw[kk][j]));
            acc = acc >>> FRAC_W;
            if (acc > 32767)       v = 16'h7FFF;
            else if (acc < -32768) v = 16'h8000;
            else                   v = acc[15:0];
            row[j*16 +: 16] = v;
        end
        return row;
    endfunction

    task automatic load_pattern(input int pat);
        for (int i = 0; i < SA_R; i++)
            for (int k = 0; k < K_MAX; k++) begin
                case (pat)
                    0:       gx[i][k] = (i == k) ? 16'h2000 : 16'h0000;
                    1:       gx[i][k] = 16'h7FFF;
                    default: gx[i][k] = 16'h8000;
                endcase
            end
        for (int k = 0; k < K_MAX; k++)
            for (int j = 0; j < SA_C; j++)
                gw[k][j] = (pat == 0) ? 16'((k + 1) * 16'h0400) : 16'h7FFF;
    endtask

    task automatic run_job(input logic [6:0] k_len, input int k_eff, input int bub,
                           input int st_row, input int st_len, input bit rnd_rdy,
                           input bit glitch, input int exp_first);
        int t0, beat, guard, last_acc, nrow, stall_cnt, ndone;
        bit rdy_seen;
        I_START = 1'b1;
        I_K_LEN = k_len;
        t0 = cyc;
        step();
        I_START = 1'b0;
        I_K_LEN = 7'($urandom);
        beat = 0; guard = 0; last_acc = 0; rdy_seen = 1'b0;
        while (beat < k_eff && guard < 2000) begin
            logic v;
            case (bub)
                0:       v = 1'b1;
                1:       v = (guard % 2) == 1;
                default: v = 1'($urandom % 2);
            endcase
            I_START = 1'b0;
            if (glitch && guard == 1) begin
                I_START = 1'b1;
                I_K_LEN = 7'd1;
            end
            I_IN_VLD = v;
            for (int i = 0; i < SA_R; i++) I_X[i*16 +: 16] = v ? gx[i][beat] : 16'($urandom);
            for (int j = 0; j < SA_C; j++) I_W[j*16 +: 16] = v ? gw[beat][j] : 16'($urandom);
            chk("in_rdy_load", {63'd0, O_IN_RDY}, 64'd1);
            if (v) last_acc = cyc - t0;
            step();
            if (v) beat++;
            guard++;
        end
        I_IN_VLD = 1'b0;
        I_START  = 1'b0;
        if (guard >= 2000) begin
            timeout("load");
            return;
        end
        guard = 0;
        while (O_OUT_VLD !== 1'b1 && guard < 2000) begin
            if (O_IN_RDY === 1'b1) rdy_seen = 1'b1;
            chk("row_zero_novld", O_OUT_ROW, 64'd0);
            chk("idx_zero_novld", {62'd0, O_ROW_IDX}, 64'd0);
            step();
            guard++;
        end
        if (guard >= 2000) begin
            timeout("first_vld");
            return;
        end
        if (k_eff == 0) chk("k0_no_in_rdy", {63'd0, rdy_seen}, 64'd0);
        chk("first_vld_cycle", 64'(cyc - t0),
            64'((exp_first >= 0) ? exp_first : last_acc + SA_R + SA_C));
        nrow = 0; stall_cnt = 0; ndone = 0; guard = 0;
        while (nrow < SA_R && guard < 2000) begin
            bit r;
            if (O_DONE === 1'b1) ndone++;
            chk("out_vld_drain", {63'd0, O_OUT_VLD}, 64'd1);
            r = rnd_rdy ? 1'($urandom % 3 != 0) : 1'b1;
            if (nrow == st_row && stall_cnt < st_len) begin
                r = 1'b0;
                stall_cnt++;
            end
            chk("row_idx", {62'd0, O_ROW_IDX}, 64'(nrow));
            chk("row_data", O_OUT_ROW, exp_rows[nrow]);
            I_OUT_RDY = r;
            if (r) nrow++;
            step();
            guard++;
        end
        I_OUT_RDY = 1'b0;
        if (guard >= 2000) begin
            timeout("drain");
            return;
        end
        if (O_DONE === 1'b1) ndone++;
        chk("done_after_last", {63'd0, O_DONE}, 64'd1);
        chk("busy_after_last", {63'd0, O_BUSY}, 64'd0);
        step();
        if (O_DONE === 1'b1) ndone++;
        chk("done_count", 64'(ndone), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        I_SYNC_RST = 1'b1; I_START = 1'b0; I_K_LEN = '0; I_IN_VLD = 1'b0;
        I_X = '0; I_W = '0; I_OUT_RDY = 1'b0;

        tbl[0] = '{7'd4, 0, 0, -1, 0, 1'b0, 12,
                   {rep4(16'h1000), rep4(16'h0C00), rep4(16'h0800), rep4(16'h0400)}};
        tbl[1] = '{7'd4, 1, 0, -1, 0, 1'b0, 12, {4{rep4(16'h7FFF)}}};
        tbl[2] = '{7'd4, 2, 0, -1, 0, 1'b0, 12, {4{rep4(16'h8000)}}};
        tbl[3] = '{7'd4, 0, 1, -1, 0, 1'b0, 16,
                   {rep4(16'h1000), rep4(16'h0C00), rep4(16'h0800), rep4(16'h0400)}};
        tbl[4] = '{7'd4, 0, 0, 1, 5, 1'b0, 12,
                   {rep4(16'h1000), rep4(16'h0C00), rep4(16'h0800), rep4(16'h0400)}};
        tbl[5] = '{7'd0, 0, 0, -1, 0, 1'b0, 8, {4{64'd0}}};
        tbl[6] = '{7'd4, 0, 0, -1, 0, 1'b1, 12,
                   {rep4(16'h1000), rep4(16'h0C00), rep4(16'h0800), rep4(16'h0400)}};

        repeat (3) step();
        chk("rst_busy", {63'd0, O_BUSY}, 64'd0);
        chk("rst_out_vld", {63'd0, O_OUT_VLD}, 64'd0);
        I_SYNC_RST = 1'b0;
        step();
        chk("idle_busy", {63'd0, O_BUSY}, 64'd0);
        chk("idle_in_rdy", {63'd0, O_IN_RDY}, 64'd0);
        chk("idle_out_row", O_OUT_ROW, 64'd0);
        chk("idle_row_idx", {62'd0, O_ROW_IDX}, 64'd0);
        chk("idle_done", {63'd0, O_DONE}, 64'd0);

        for (int t = 0; t < 7; t++) begin
            load_pattern(tbl[t].pat);
            for (int r = 0; r < SA_R; r++) exp_rows[r] = tbl[t].rows[r];
            run_job(tbl[t].k, int'(tbl[t].k), tbl[t].bub, tbl[t].st_row, tbl[t].st_len,
                    1'b0, tbl[t].glitch, tbl[t].first);
        end

        // Abort during FLUSH with saturating data in flight
        begin
            int nd;
            load_pattern(1);
            I_START = 1'b1; I_K_LEN = 7'd4;
            step();
            I_START = 1'b0;
            for (int k = 0; k < 4; k++) begin
                I_IN_VLD = 1'b1;
                for (int i = 0; i < SA_R; i++) I_X[i*16 +: 16] = gx[i][k];
                for (int j = 0; j < SA_C; j++) I_W[j*16 +: 16] = gw[k][j];
                step();
            end
            I_IN_VLD = 1'b0;
            step(); step();
            chk("flush_busy", {63'd0, O_BUSY}, 64'd1);
            chk("flush_in_rdy", {63'd0, O_IN_RDY}, 64'd0);
            I_SYNC_RST = 1'b1;
            step();
            I_SYNC_RST = 1'b0;
            chk("abort_busy", {63'd0, O_BUSY}, 64'd0);
            chk("abort_out_vld", {63'd0, O_OUT_VLD}, 64'd0);
            chk("abort_out_row", O_OUT_ROW, 64'd0);
            chk("abort_done", {63'd0, O_DONE}, 64'd0);
            nd = 0;
            for (int c = 0; c < 30; c++) begin
                if (O_DONE === 1'b1 || O_OUT_VLD === 1'b1) nd++;
                step();
            end
            chk("abort_no_done", 64'(nd), 64'd0);
            load_pattern(0);
            for (int r = 0; r < SA_R; r++) exp_rows[r] = tbl[0].rows[r];
            run_job(7'd4, 4, 0, -1, 0, 1'b0, 1'b0, 12);
        end

        // Random jobs against the arithmetic model; last one exercises K clamping
        for (int n = 0; n < 7; n++) begin
            int ke;
            logic [6:0] kl;
            if (n == 6) begin
                kl = 7'd100;
                ke = K_MAX;
            end else begin
                ke = int'($urandom_range(1, 20));
                kl = 7'(ke);
            end
            for (int i = 0; i < SA_R; i++)
                for (int k = 0; k < K_MAX; k++)
                    gx[i][k] = (n % 2 == 0) ? 16'($urandom) : 16'($urandom_range(0, 8191) - 4096);
            for (int k = 0; k < K_MAX; k++)
                for (int j = 0; j < SA_C; j++)
                    gw[k][j] = (n % 2 == 0) ? 16'($urandom) : 16'($urandom_range(0, 8191) - 4096);
            for (int r = 0; r < SA_R; r++) exp_rows[r] = model_row(r, ke);
            if (n == 6) run_job(kl, ke, 0, -1, 0, 1'b0, 1'b0, K_MAX + SA_R + SA_C);
            else        run_job(kl, ke, 2, -1, 0, 1'b1, 1'b0, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sa_os_stream.md
Name: sa_os_stream

Overview:
- Output-stationary systolic matrix-multiply engine, the parametrised successor of the fixed 16x16 SA used in the MHA datapath.
- Computes OUT[SA_R x SA_C] = X[SA_R x K] * W[K x SA_C] for a run-time inner dimension K up to K_MAX.
- Provides its own input skew buffers, per-beat valid/ready input with bubble tolerance, and a saturating fixed-point accumulator in every PE.
- Drains results one row per handshake, so the downstream softmax/accumulate stages can backpressure it.

Parameters:
- D_W, 16, data width, signed fixed point (1 sign bit, D_W-1-FRAC_W integer bits, FRAC_W fraction bits).
- FRAC_W, 13, number of fraction bits.
- SA_R, 16, array rows (X lanes, left edge).
- SA_C, 16, array columns (W lanes, top edge).
- K_MAX, 64, maximum inner dimension; K_W = $clog2(K_MAX+1).

Ports:
- I_CLK  in  1  clock; the only clock.
- I_SYNC_RST  in  1  reset, synchronous, active-high.
- I_START  in  1  start pulse; sampled only in IDLE.
- I_K_LEN  in  K_W  inner dimension K; latched on accepted I_START.
- O_BUSY  out  1  high whenever state is not IDLE.
- I_IN_VLD  in  1  input beat valid.
- O_IN_RDY  out  1  input beat ready; high only in LOAD.
- I_X  in  SA_R*D_W  X column k; lane i at [i*D_W +: D_W].
- I_W  in  SA_C*D_W  W row k; lane j at [j*D_W +: D_W].
- O_OUT_VLD  out  1  result row valid.
- I_OUT_RDY  in  1  result row ready.
- O_OUT_ROW  out  SA_C*D_W  saturated row O_ROW_IDX; column j at [j*D_W +: D_W].
- O_ROW_IDX  out  $clog2(SA_R)  index of the row on O_OUT_ROW.
- O_DONE  out  1  one-cycle pulse after the last row handshake.

Behaviour:
- Reset (synchronous, I_SYNC_RST=1 at a clock edge): state IDLE; all accumulators, skew registers and valid bits cleared; all outputs 0. Reset in any state aborts the operation; no O_DONE is produced.
- States: IDLE, LOAD, FLUSH, DRAIN.
  - IDLE: on I_START, latch K. K=0 goes to FLUSH; otherwise to LOAD. Accumulators clear on this transition.
  - LOAD: O_IN_RDY=1. A beat is accepted when I_IN_VLD&O_IN_RDY. The beat counter advances per accepted beat. When beat K-1 is accepted, go to FLUSH.
  - FLUSH: fixed SA_R+SA_C-1 cycles, counted by the flush counter. Then go to DRAIN.
  - DRAIN: rows 0..SA_R-1 are presented in order. Row r is held stable while O_OUT_VLD&!I_OUT_RDY. After row SA_R-1 is accepted: O_DONE=1 for one cycle and state returns to IDLE.
- I_START outside IDLE is ignored. I_K_LEN>K_MAX is clamped to K_MAX.
- Skew: X lane i is delayed i cycles and W lane j is delayed j cycles. Each lane carries a valid bit equal to the accepted-beat strobe.
- The array shifts every cycle:
  - X moves left to right, W moves top to bottom, one register per PE.
  - Beat k accepted at cycle t reaches PE(i,j) at edge t+i+j+1.
  - Idle cycles in LOAD (I_IN_VLD=0) inject bubbles with valid=0.
- PE accumulation: PE(i,j) accumulates only when both its x and w valid bits are 1.
  - Product: full 2*D_W signed.
  - Accumulator width: 2*D_W + $clog2(K_MAX). The accumulator never overflows internally.
- Output conversion, per element:
  - Arithmetic shift right by FRAC_W (floor).
  - Then saturate to D_W signed: max 0x7FFF, min 0x8000 for D_W=16.
- Latency, continuous input:
  - I_START at cycle 0 gives LOAD in cycles 1..K and FLUSH in cycles K+1..K+SA_R+SA_C-1.
  - First O_OUT_VLD appears in cycle K+SA_R+SA_C.
  - Each stalled input cycle adds one cycle.
- K=0: no input beats are accepted; all SA_R rows drain as zeros.
- O_ROW_IDX is 0 outside DRAIN.
- O_OUT_ROW is 0 when O_OUT_VLD=0.

Test Plan:
- Identity: SA_R=SA_C=4, K=4, X=I (0x2000 on the diagonal), W[k][j]=0x0400*(k+1) -> row r = {0x0400*(r+1)} x4; first O_OUT_VLD at cycle 12 after I_START; O_DONE one cycle after the row-3 handshake.
- Saturation: K=4, all X=0x7FFF, all W=0x7FFF -> every element 0x7FFF; all X=0x8000, W=0x7FFF -> every element 0x8000.
- Bubbles: K=4 identity case with I_IN_VLD low on alternating cycles -> identical results; first O_OUT_VLD delayed by exactly 4 cycles (cycle 16).
- Backpressure: I_OUT_RDY low for 5 cycles while row 1 is presented -> O_OUT_ROW and O_ROW_IDX stay constant at row 1; no row is skipped or duplicated; O_DONE pulses exactly once.
- Edge cases: K=0 -> O_IN_RDY never asserts and 4 zero rows drain; I_START during LOAD -> ignored, K unchanged.
- Mid-operation reset: I_SYNC_RST for 1 cycle during FLUSH -> next cycle IDLE with all outputs 0 and no O_DONE; a new K=4 run then matches the identity result exactly, proving the accumulators were cleared.
